// File: rtl/lsi_echo_pkg.sv
// Shared definitions for the echo memory: mode encodings, CSR bit map, FSM states
// and the per-byte case conversion helper.
package lsi_echo_pkg;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_UPPER = 2'd1,
    MODE_LOWER = 2'd2,
    MODE_SWAP  = 2'd3
  } mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  localparam int MODE_LSB    = 0;
  localparam int BUSY_BIT    = 2;
  localparam int DROP_BIT    = 3;
  localparam int CLEAR_BIT   = 8;
  localparam int STATCLR_BIT = 9;

  function automatic logic [7:0] conv_byte(input logic [7:0] b, input mode_e m);
    logic       is_lo;
    logic       is_up;
    logic [7:0] r;
    is_lo = (b >= 8'd97) && (b <= 8'd122);
    is_up = (b >= 8'd65) && (b <= 8'd90);
    r     = b;
    case (m)
      MODE_PASS:  r = b;
      MODE_UPPER: r = is_lo ? (b - 8'd32) : b;
      MODE_LOWER: r = is_up ? (b + 8'd32) : b;
      MODE_SWAP:  r = is_lo ? (b - 8'd32) : (is_up ? (b + 8'd32) : b);
      default:    r = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsi_echo_conv.sv
// Combinational case converter applied independently to every byte of a word.
module lsi_echo_conv
  import lsi_echo_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  mode_e              mode,
  input  logic [DATA_W-1:0]  data_in,
  output logic [DATA_W-1:0]  data_out
);

  // per-byte conversion
  always_comb begin
    data_out = data_in;
    for (int i = 0; i < DATA_W / 8; i++) begin
      data_out[i*8 +: 8] = conv_byte(data_in[i*8 +: 8], mode);
    end
  end

endmodule

// File: rtl/lsi_echo_mem.sv
// Echo memory behind the ezusb_lsi strobe interface, with CSR at the top address
// and a clear sequencer. Optional write counter in the CSR under LSI_ECHO_STATS_EN.
module lsi_echo_mem
  import lsi_echo_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 8,
  parameter int RESET_MODE = 1
) (
  input  logic              fxclk,
  input  logic              reset_in_n,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_strobe,
  input  logic [ADDR_W-1:0] out_addr,
  input  logic              out_strobe,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] CSR_ADDR  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] LAST_ADDR = {{(ADDR_W-1){1'b1}}, 1'b0};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  mode_e               mode_q, mode_d;
  logic                drop_q, drop_d;
  logic                busy_q, busy_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   mem_q [2**ADDR_W];

  logic [DATA_W-1:0]   conv_s;
  logic [DATA_W-1:0]   csr_s;
  logic                wr_csr_s, wr_ram_s, rd_csr_s;
  logic                mem_we_s;
  logic [ADDR_W-1:0]   mem_waddr_s;
  logic [DATA_W-1:0]   mem_wdata_s;

  assign wr_csr_s = in_strobe && (in_addr == CSR_ADDR);
  assign wr_ram_s = in_strobe && (in_addr != CSR_ADDR);
  assign rd_csr_s = out_strobe && (out_addr == CSR_ADDR);

  lsi_echo_conv #(.DATA_W(DATA_W)) u_conv (
    .mode     (mode_q),
    .data_in  (in_data),
    .data_out (conv_s)
  );

`ifdef LSI_ECHO_STATS_EN
  logic [15:0]          wr_cnt_q, wr_cnt_d;
  logic [15:0]          rd_cnt_q, rd_cnt_d;
  logic [DATA_W+31:0]   csr_wide_s;

  // saturating activity counters, cleared through the CSR
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (wr_csr_s && in_data[STATCLR_BIT]) begin
      wr_cnt_d = 16'd0;
      rd_cnt_d = 16'd0;
    end else begin
      if (wr_ram_s && (state_q == IDLE) && (wr_cnt_q != 16'hFFFF)) begin
        wr_cnt_d = wr_cnt_q + 16'd1;
      end else begin
        wr_cnt_d = wr_cnt_q;
      end
      if (out_strobe && !rd_csr_s && (rd_cnt_q != 16'hFFFF)) begin
        rd_cnt_d = rd_cnt_q + 16'd1;
      end else begin
        rd_cnt_d = rd_cnt_q;
      end
    end
  end

  always_ff @(posedge fxclk or negedge reset_in_n) begin
    if (!reset_in_n) begin
      wr_cnt_q <= 16'd0;
      rd_cnt_q <= 16'd0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  assign csr_wide_s = {{DATA_W{1'b0}}, wr_cnt_q, 16'h0000};
`endif

  always_comb begin
    csr_s = '0;
    csr_s[MODE_LSB +: 2] = mode_q;
    csr_s[BUSY_BIT]      = busy_q;
    csr_s[DROP_BIT]      = drop_q;
`ifdef LSI_ECHO_STATS_EN
    csr_s = csr_s | csr_wide_s[DATA_W-1:0];
`else
    csr_s = csr_s;
`endif
  end

  // control: mode, clear sequencer, drop flag, read port
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    drop_d      = drop_q;
    out_data_d  = out_data_q;
    out_valid_d = out_strobe;
    mem_we_s    = 1'b0;
    mem_waddr_s = in_addr;
    mem_wdata_s = conv_s;

    if (wr_csr_s) begin
      mode_d = mode_e'(in_data[MODE_LSB +: 2]);
    end else begin
      mode_d = mode_q;
    end

    case (state_q)
      IDLE: begin
        if (wr_csr_s && in_data[CLEAR_BIT]) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == CLEAR);

    // the sequencer owns the single write port while clearing
    if (state_q == CLEAR) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = cnt_q;
      mem_wdata_s = '0;
    end else if (wr_ram_s) begin
      mem_we_s    = 1'b1;
    end else begin
      mem_we_s    = 1'b0;
    end

    if (rd_csr_s) begin
      drop_d = 1'b0;
    end else begin
      drop_d = drop_q;
    end
    if ((state_q == CLEAR) && wr_ram_s) begin
      drop_d = 1'b1;
    end else begin
      drop_d = drop_d;
    end

    if (out_strobe) begin
      out_data_d = rd_csr_s ? csr_s : mem_q[out_addr];
    end else begin
      out_data_d = out_data_q;
    end
  end

  always_ff @(posedge fxclk) begin
    if (mem_we_s) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

  always_ff @(posedge fxclk or negedge reset_in_n) begin
    if (!reset_in_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mode_q      <= mode_e'(RESET_MODE[1:0]);
      drop_q      <= 1'b0;
      busy_q      <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      drop_q      <= drop_d;
      busy_q      <= busy_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_lsi_echo_mem.sv
// Directed self-checking bench for lsi_echo_mem (default build, 32-bit x 256).
module tb_lsi_echo_mem;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam logic [AW-1:0] CSR = 8'hFF;

  logic          fxclk = 1'b0;
  logic          reset_in_n;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          in_strobe;
  logic [AW-1:0] out_addr;
  logic          out_strobe;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  lsi_echo_mem #(.DATA_W(DW), .ADDR_W(AW), .RESET_MODE(1)) dut (
    .fxclk      (fxclk),
    .reset_in_n (reset_in_n),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .in_strobe  (in_strobe),
    .out_addr   (out_addr),
    .out_strobe (out_strobe),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .busy       (busy)
  );

  always #5 fxclk = ~fxclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    in_addr   = a;
    in_data   = d;
    in_strobe = 1'b1;
    @(posedge fxclk); #1;
    in_strobe = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic v);
    out_addr   = a;
    out_strobe = 1'b1;
    @(posedge fxclk); #1;
    out_strobe = 1'b0;
    d = out_data;
    v = out_valid;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 400) begin
      n++;
      @(posedge fxclk); #1;
    end
  endtask

  logic [DW-1:0] d;
  logic          v;
  int            n;

  initial begin
    reset_in_n = 1'b0;
    in_addr = '0; in_data = '0; in_strobe = 1'b0;
    out_addr = '0; out_strobe = 1'b0;
    #12;
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge fxclk); #1;
    reset_in_n = 1'b1;
    rd(CSR, d, v);
    chk("csr_after_reset", d, 32'h1);

    // upper-case mode
    wr(8'd5, 32'h61627A7B);
    rd(8'd5, d, v);
    chk("upper_valid", {31'd0, v}, 32'd1);
    chk("upper_data", d, 32'h41425A7B);
    @(posedge fxclk); #1;
    chk("valid_pulse_low", {31'd0, out_valid}, 32'd0);
    chk("data_hold", out_data, 32'h41425A7B);

    // lower, swap, pass
    wr(CSR, 32'h2);
    wr(8'd6, 32'h41425A40);
    rd(8'd6, d, v);
    chk("lower_data", d, 32'h61627A40);
    wr(CSR, 32'h3);
    wr(8'd6, 32'h61415A7A);
    rd(8'd6, d, v);
    chk("swap_data", d, 32'h41617A5A);
    wr(CSR, 32'h0);
    wr(8'd8, 32'h61414243);
    rd(8'd8, d, v);
    chk("pass_data", d, 32'h61414243);

    // clear sequencer timing and effect
    wr(CSR, 32'h1);
    for (int i = 0; i < 4; i++) wr(i[AW-1:0], 32'h30313233 + i);
    rd(8'd2, d, v);
    chk("pre_clear_data", d, 32'h30313235);
    wr(CSR, 32'h101);
    chk("busy_rise", {31'd0, busy}, 32'd1);
    wait_idle(n);
    chk("busy_cycles", n, 32'd255);
    for (int i = 0; i < 4; i++) begin
      rd(i[AW-1:0], d, v);
      chk("cleared_data", d, 32'h0);
    end
    rd(CSR, d, v);
    chk("csr_after_clear", {16'd0, d[15:0]}, 32'h1);

    // dropped write and mode write while clearing
    wr(8'd10, 32'h31313131);
    wr(CSR, 32'h101);
    rd(CSR, d, v);
    chk("csr_busy_bit", {16'd0, d[15:0]}, 32'h5);
    wr(8'd10, 32'h12345678);
    wr(CSR, 32'h2);
    wait_idle(n);
    chk("wait_idle_bound", {31'd0, busy}, 32'd0);
    rd(8'd10, d, v);
    chk("dropped_write", d, 32'h0);
    rd(CSR, d, v);
    chk("csr_drop_set", {16'd0, d[15:0]}, 32'hA);
    rd(CSR, d, v);
    chk("csr_drop_clr", {16'd0, d[15:0]}, 32'h2);
    wr(CSR, 32'h1);

    // same-cycle read and write
    wr(8'd7, 32'h22222222);
    in_addr = 8'd7; in_data = 32'h11111111; in_strobe = 1'b1;
    out_addr = 8'd7; out_strobe = 1'b1;
    @(posedge fxclk); #1;
    in_strobe = 1'b0; out_strobe = 1'b0;
    chk("rw_old_data", out_data, 32'h22222222);
    rd(8'd7, d, v);
    chk("rw_new_data", d, 32'h11111111);

    // reset in the middle of a clear
    wr(8'd250, 32'h55555555);
    wr(CSR, 32'h103);
    repeat (98) @(posedge fxclk);
    #1;
    out_addr = 8'd5; out_strobe = 1'b1;
    @(posedge fxclk); #1;
    out_strobe = 1'b0;
    chk("mid_clear_busy", {31'd0, busy}, 32'd1);
    chk("mid_clear_valid", {31'd0, out_valid}, 32'd1);
    #2 reset_in_n = 1'b0;
    #1;
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_valid", {31'd0, out_valid}, 32'd0);
    chk("async_data", out_data, 32'h0);
    @(posedge fxclk); #1;
    reset_in_n = 1'b1;
    rd(CSR, d, v);
    chk("csr_after_midreset", d, 32'h1);
    rd(8'd250, d, v);
    chk("partial_clear_kept", d, 32'h55555555);
    rd(8'd2, d, v);
    chk("partial_clear_zero", d, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
